reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-read-port integer register file for the ArmCore datapath. It generalises the 32 × 64-bit X-register file to configurable width, depth and read-port count. It adds four behaviours:
- a hardwired zero register (XZR);
- 32-bit W-register writes with zero-extension;
- a sequential post-reset clear engine;
- optional same-cycle write-to-read bypass.

It sits between decode (register addresses) and execute/writeback (operands, results).

## Interface
Parameters:
- DATA_W, 64, register width in bits (≥ 33).
- NUM_REGS, 32, number of architectural registers (power of two, ≥ 2).
- NUM_RD, 2, number of independent read ports (1–4).
- ZERO_REG, 31, index that reads as zero and ignores writes. A value ≥ NUM_REGS disables this behaviour.
- Derived: AW = clog2(NUM_REGS).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- reg_write, input, 1, write enable.
- wr_w32, input, 1, selects a 32-bit write: store {zeros, wr_data[31:0]}.
- wr_addr, input, AW, write register index.
- wr_data, input, DATA_W, write data.
- rd_addr, input, NUM_RD*AW, read indices; port k uses bits [k*AW +: AW].
- rd_data, output, NUM_RD*DATA_W, read data; port k uses bits [k*DATA_W +: DATA_W].
- init_busy, output, 1, high while the clear engine runs; the core must stall.

## Operation
- Storage is an array of NUM_REGS × DATA_W. Array contents are not reset by rst_n; the clear engine zeroes them.
- The FSM has two states: INIT and READY.
  - rst_n low puts the FSM in INIT immediately: clr_idx = 0, init_busy = 1, every rd_data = 0.
  - In INIT, each rising edge with rst_n high writes zero to entry clr_idx, then increments clr_idx.
  - When clr_idx reaches NUM_REGS−1, INIT → READY after that edge's write completes.
  - READY holds until the next reset.
- The clear engine has write priority. While in INIT, reg_write is ignored and the write is dropped, not queued.
- Writes in READY: on a rising edge with reg_write = 1 and wr_addr ≠ ZERO_REG, the entry is written.
  - The value is wr_data when wr_w32 = 0.
  - The value is {(DATA_W−32)'b0, wr_data[31:0]} when wr_w32 = 1.
  - A write to ZERO_REG is discarded.
- Reads are combinational, and each port is independent:
  - In INIT: rd_data = 0.
  - rd_addr = ZERO_REG: rd_data = 0.
  - Otherwise: the stored entry, or the bypassed value (see Configuration).
- Any combination of ports may read the same index and all receive identical data. Reading and writing the same index in one cycle is legal.
- Reset asserted mid-INIT or mid-operation immediately returns the block to INIT with clr_idx = 0, and the full clear sequence restarts.

## Timing
- Reset values: init_busy = 1, all rd_data = 0, state = INIT, clr_idx = 0.
- Clear latency: exactly NUM_REGS rising edges after rst_n deasserts. init_busy falls after edge NUM_REGS; with default parameters it is low from edge 32 onward.
- The first accepted write is at edge NUM_REGS+1, i.e. the first edge sampled with init_busy = 0.
- Write latency: one edge. Without bypass, data is visible on reads in the cycle after the write edge.
- Read latency: zero cycles (combinational from rd_addr and the array, plus the bypass path when enabled).
- No handshake other than init_busy. The block always accepts a write in READY.

## Configuration
- Macro REG_FILE_BYPASS_EN.
- Defined:
  - Condition: in READY, reg_write = 1, wr_addr ≠ ZERO_REG and rd_addr[k] = wr_addr.
  - Effect: port k returns the pending write value in the same cycle.
  - wr_w32 zero-extension applies to the bypassed value.
  - Use: lets execute consume a writeback result without a stall.
- Undefined: a read of the index being written returns the old stored value until after the write edge.
- In both builds, the INIT and ZERO_REG rules take precedence over bypass.

## Test plan
- Reset → clear: preload garbage via backdoor, pulse rst_n low, release → init_busy is high for exactly 32 edges. Afterwards all 32 indices read 0 on both ports.
- Write/read: write X5 = 0x0123_4567_89AB_CDEF, next cycle read port0 = 5 and port1 = 5 → both return 0x0123_4567_89AB_CDEF. Writing X31 = 0xFFFF… then reading X31 returns 0.
- W-write: X7 holds 0xFFFF_FFFF_FFFF_FFFF. Write X7 with wr_w32 = 1 and wr_data = 0xAAAA_BBBB_1234_5678 → X7 reads 0x0000_0000_1234_5678.
- Write during INIT: assert reg_write to X3 = 0x55 on edge 10 after reset release → dropped; X3 reads 0 after init_busy falls.
- Bypass: X9 holds 0x11. In the same cycle write X9 = 0x22 and read X9 on port0.
  - With REG_FILE_BYPASS_EN defined: returns 0x22.
  - Without it: returns 0x11, then 0x22 the next cycle.
- Mid-clear reset: assert rst_n low at clear edge 15, release → init_busy stays high for a further full 32 edges. Every entry reads 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with hardwired zero register, W-register writes and a post-reset clear engine.
// Optional same-cycle write-to-read bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_mp #(
  parameter  int DATA_W   = 64,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 31,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reg_write,
  input  logic                     wr_w32,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     init_busy
);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  localparam bit             ZERO_EN  = (ZERO_REG < NUM_REGS);
  localparam logic [AW-1:0]  LAST_IDX = AW'(NUM_REGS - 1);

  state_t              state;
  logic [AW-1:0]       clr_idx;
  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [DATA_W-1:0]   wr_value;
  logic                user_we;
  logic                ready;

  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return ZERO_EN && (int'(addr) == ZERO_REG);
  endfunction

  assign ready    = (state == READY);
  assign wr_value = wr_w32 ? {{(DATA_W-32){1'b0}}, wr_data[31:0]} : wr_data;
  // Writes arriving during the clear sequence are dropped, never queued.
  assign user_we  = ready && reg_write && !is_zero_reg(wr_addr);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_idx   <= '0;
      init_busy <= 1'b1;
    end else if (state == INIT) begin
      if (clr_idx == LAST_IDX) begin
        state     <= READY;
        init_busy <= 1'b0;
      end else begin
        clr_idx <= clr_idx + 1'b1;
      end
    end
  end

  // NOTE: the array has no reset term so it maps onto plain RAM; the clear engine zeroes it instead.
  always_ff @(posedge clk) begin
    if (rst_n && (state == INIT)) begin
      mem[clr_idx] <= '0;
    end else if (user_we) begin
      mem[wr_addr] <= wr_value;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     addr;
    logic              fwd;
    logic [DATA_W-1:0] word;

    assign addr = rd_addr[k*AW +: AW];
`ifdef REG_FILE_BYPASS_EN
    assign fwd  = user_we && (addr == wr_addr);
`else
    assign fwd  = 1'b0;
`endif
    assign word = fwd ? wr_value : mem[addr];
    // INIT and the zero register override both the array and the bypass path.
    assign rd_data[k*DATA_W +: DATA_W] = (ready && !is_zero_reg(addr)) ? word : '0;
  end

endmodule
